// File: rtl/buff_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// buff_sched_ctrl_if : host/config and buffer-bank signals of buff_sched_ctrl
// Optional abort_ctrl present when BUFF_SCHED_ABORT_EN is defined.
// Revision: 1.0
// ============================================================================
interface buff_sched_ctrl_if #(
  parameter int NUM_BUFS   = 12,
  parameter int MAX_PERIOD = 64,
  parameter int AW         = $clog2(MAX_PERIOD),
  parameter int ITW        = 16
);
  localparam int CW = 2 * NUM_BUFS;

  logic [CW-1:0]       ctrl_in;
  logic                load_ctrl;
  logic [AW-1:0]       period_m1;
  logic [CW-1:0]       stretch_mask;
  logic [ITW-1:0]      num_iter;
  logic                start_ctrl;
  logic                stop_ctrl;
`ifdef BUFF_SCHED_ABORT_EN
  logic                abort_ctrl;
`endif
  logic [NUM_BUFS-1:0] buff_wr_toggle;
  logic [NUM_BUFS-1:0] buff_rd_toggle;
  logic                active;
  logic [ITW-1:0]      iter_cnt;
  logic                done;
  logic                load_err;

  modport master (
    output ctrl_in, load_ctrl, period_m1, stretch_mask, num_iter, start_ctrl, stop_ctrl,
`ifdef BUFF_SCHED_ABORT_EN
    output abort_ctrl,
`endif
    input  buff_wr_toggle, buff_rd_toggle, active, iter_cnt, done, load_err
  );

  modport slave (
    input  ctrl_in, load_ctrl, period_m1, stretch_mask, num_iter, start_ctrl, stop_ctrl,
`ifdef BUFF_SCHED_ABORT_EN
    input  abort_ctrl,
`endif
    output buff_wr_toggle, buff_rd_toggle, active, iter_cnt, done, load_err
  );
endinterface
`default_nettype wire

// File: rtl/buff_sched_ctrl.sv
`default_nettype none
// ============================================================================
// buff_sched_ctrl : replays a programmable schedule RAM as buffer toggle strobes
// Optional macro BUFF_SCHED_ABORT_EN adds an immediate abort input.
// Revision: 1.0
// ============================================================================
module buff_sched_ctrl #(
  parameter int NUM_BUFS   = 12,
  parameter int MAX_PERIOD = 64,
  parameter int AW         = $clog2(MAX_PERIOD),
  parameter int ITW        = 16
) (
  input  logic               clk,
  input  logic               rst,
  buff_sched_ctrl_if.slave   bus
);
  localparam int CW = 2 * NUM_BUFS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [AW-1:0]  last_q, last_d;
  logic [CW-1:0]  mask_q, mask_d;
  logic [CW-1:0]  prev_q, prev_d;
  logic [CW-1:0]  out_q, out_d;
  logic [ITW-1:0] num_iter_q, num_iter_d;
  logic [ITW-1:0] iter_cnt_q, iter_cnt_d;
  logic           stop_pending_q, stop_pending_d;
  logic           done_q, done_d;
  logic           load_err_q, load_err_d;

  logic [CW-1:0]  sched_mem [MAX_PERIOD];
  logic [CW-1:0]  cur_word;
  logic           mem_we;
  logic           abort_req;
  logic           last_iter;

  assign cur_word  = sched_mem[rd_addr_q];
  assign last_iter = (num_iter_q != '0) &&
                     ((ITW+1)'(iter_cnt_q) + 1'b1 == (ITW+1)'(num_iter_q));

`ifdef BUFF_SCHED_ABORT_EN
  assign abort_req = bus.abort_ctrl;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    last_d         = last_q;
    mask_d         = mask_q;
    prev_d         = prev_q;
    out_d          = out_q;
    num_iter_d     = num_iter_q;
    iter_cnt_d     = iter_cnt_q;
    stop_pending_d = stop_pending_q;
    done_d         = 1'b0;
    load_err_d     = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        out_d  = '0;
        prev_d = '0;
        if (bus.load_ctrl) begin
          mem_we    = 1'b1;
          wr_addr_d = (wr_addr_q == bus.period_m1 || wr_addr_q == LAST_ADDR) ?
                      '0 : wr_addr_q + 1'b1;
        end
        // A simultaneous stop request is dropped by the fresh stop_pending clear.
        if (bus.start_ctrl) begin
          state_d        = S_RUN;
          last_d         = (bus.period_m1 > LAST_ADDR) ? LAST_ADDR : bus.period_m1;
          mask_d         = bus.stretch_mask;
          num_iter_d     = bus.num_iter;
          rd_addr_d      = '0;
          iter_cnt_d     = '0;
          stop_pending_d = 1'b0;
        end
      end

      S_RUN: begin
        load_err_d = bus.load_ctrl;
        out_d      = cur_word | (mask_q & prev_q);
        prev_d     = cur_word;
        if (bus.stop_ctrl) begin
          stop_pending_d = 1'b1;
        end
        if (rd_addr_q == last_q) begin
          rd_addr_d = '0;
          if (iter_cnt_q != '1) begin
            iter_cnt_d = iter_cnt_q + 1'b1;
          end
          // A stop arriving on the final cycle of an iteration still ends here.
          if (stop_pending_q || bus.stop_ctrl || last_iter) begin
            state_d = S_DRAIN;
          end
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end

      S_DRAIN: begin
        load_err_d     = bus.load_ctrl;
        out_d          = mask_q & prev_q;
        prev_d         = '0;
        stop_pending_d = 1'b0;
        done_d         = 1'b1;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_req && state_q != S_IDLE) begin
      state_d        = S_IDLE;
      out_d          = '0;
      prev_d         = '0;
      done_d         = 1'b0;
      iter_cnt_d     = iter_cnt_q;
      stop_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      last_q         <= '0;
      mask_q         <= '0;
      prev_q         <= '0;
      out_q          <= '0;
      num_iter_q     <= '0;
      iter_cnt_q     <= '0;
      stop_pending_q <= 1'b0;
      done_q         <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      last_q         <= last_d;
      mask_q         <= mask_d;
      prev_q         <= prev_d;
      out_q          <= out_d;
      num_iter_q     <= num_iter_d;
      iter_cnt_q     <= iter_cnt_d;
      stop_pending_q <= stop_pending_d;
      done_q         <= done_d;
      load_err_q     <= load_err_d;
    end
  end

  // Schedule contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      sched_mem[wr_addr_q] <= bus.ctrl_in;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_split
      assign bus.buff_wr_toggle[i] = out_q[2*i];
      assign bus.buff_rd_toggle[i] = out_q[2*i+1];
    end
  endgenerate

  assign bus.active   = (state_q != S_IDLE);
  assign bus.iter_cnt = iter_cnt_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;
endmodule
`default_nettype wire

// File: tb/tb_buff_sched_ctrl.sv
`default_nettype none
// ============================================================================
// tb_buff_sched_ctrl : randomized and directed bench with a schedule-level model
// Revision: 1.0
// ============================================================================
module tb_buff_sched_ctrl;
  localparam int NB   = 2;
  localparam int CW   = 2 * NB;
  localparam int MAXP = 6;
  localparam int AWT  = $clog2(MAXP);
  localparam int ITW  = 3;
  localparam int SATI = (1 << ITW) - 1;

  typedef logic [15:0] smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [CW-1:0] ram_m [MAXP];
  smp_t obs[$];
  smp_t expq[$];

  buff_sched_ctrl_if #(.NUM_BUFS(NB), .MAX_PERIOD(MAXP), .ITW(ITW)) bus ();

  buff_sched_ctrl #(.NUM_BUFS(NB), .MAX_PERIOD(MAXP), .ITW(ITW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic smp_t pack(input logic [CW-1:0] o, input logic a, input logic d,
                                input logic le, input int it);
    return 16'({o, a, d, le, ITW'(it)});
  endfunction

  function automatic smp_t sample_dut();
    logic [CW-1:0] o;
    for (int i = 0; i < NB; i++) begin
      o[2*i]   = bus.buff_wr_toggle[i];
      o[2*i+1] = bus.buff_rd_toggle[i];
    end
    return pack(o, bus.active, bus.done, bus.load_err, int'(bus.iter_cnt));
  endfunction

  function automatic int eff_period(input int pm1);
    return ((pm1 > MAXP - 1) ? MAXP - 1 : pm1) + 1;
  endfunction

  task automatic idle_inputs();
    bus.ctrl_in      = '0;
    bus.load_ctrl    = 1'b0;
    bus.start_ctrl   = 1'b0;
    bus.stop_ctrl    = 1'b0;
`ifdef BUFF_SCHED_ABORT_EN
    bus.abort_ctrl   = 1'b0;
`endif
  endtask

  task automatic load_ram(input int pm1, input bit rnd);
    int p = eff_period(pm1);
    for (int i = 0; i < p; i++) begin
      if (rnd) ram_m[i] = CW'($urandom);
      bus.ctrl_in   = ram_m[i];
      bus.load_ctrl = 1'b1;
      bus.period_m1 = AWT'(pm1);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Expected stream: the schedule unrolled over N iterations, each output word being
  // the current word plus masked bits of the word before it, then one drain word.
  task automatic run_sched(input int pm1, input logic [CW-1:0] mask, input int niter,
                           input int stop_at, input int load_at, input int rst_at,
                           input int abort_at, input bit start_stop);
    int p, n, np, last;
    p = eff_period(pm1);
    if (stop_at >= 0 && (niter == 0 || stop_at / p < niter)) n = stop_at / p + 1;
    else n = niter;
    np   = n * p;
    last = np + 2;
    obs.delete();
    expq.delete();
    for (int c = 0; c <= last; c++) begin
      logic [CW-1:0] eo;
      logic ea, ed, el;
      int ei;
      if (c == 0) eo = '0;
      else if (c <= np) eo = ram_m[(c-1) % p] | ((c >= 2) ? (mask & ram_m[(c-2) % p]) : '0);
      else if (c == np + 1) eo = mask & ram_m[(np-1) % p];
      else eo = '0;
      ea = (c <= np);
      ed = (c == np + 1);
      el = (load_at >= 0 && c == load_at + 1);
      ei = (c <= np) ? c / p : n;
      if (ei > SATI) ei = SATI;
      if (rst_at >= 0 && c > rst_at) begin
        eo = '0; ea = 0; ed = 0; el = 0; ei = 0;
      end
      if (abort_at >= 0 && c > abort_at) begin
        eo = '0; ea = 0; ed = 0; el = 0;
        ei = (abort_at / p > SATI) ? SATI : abort_at / p;
      end
      expq.push_back(pack(eo, ea, ed, el, ei));
    end

    bus.period_m1    = AWT'(pm1);
    bus.stretch_mask = mask;
    bus.num_iter     = ITW'(niter);
    bus.start_ctrl   = 1'b1;
    bus.stop_ctrl    = start_stop;
    @(posedge clk); #1;
    bus.start_ctrl   = 1'b0;
    bus.stop_ctrl    = 1'b0;
    for (int c = 0; c <= last; c++) begin
      bus.stop_ctrl = (c == stop_at);
      bus.load_ctrl = (c == load_at);
      bus.ctrl_in   = (c == load_at) ? CW'($urandom) : '0;
      rst           = (c == rst_at);
`ifdef BUFF_SCHED_ABORT_EN
      bus.abort_ctrl = (c == abort_at);
`endif
      @(negedge clk);
      obs.push_back(sample_dut());
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_ctrl = 1'b1;
    bus.load_ctrl  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (sample_dut() !== pack('0, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_hold got=%h want=%h", sample_dut(), pack('0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sample_dut() !== pack('0, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_idle got=%h want=%h", sample_dut(), pack('0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    ram_m[0] = 4'h1; ram_m[1] = 4'h2; ram_m[2] = 4'h4; ram_m[3] = 4'h8;
    load_ram(3, 0);
    run_sched(3, 4'h0, 2, -1, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL basic cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_stretch();
    run_sched(3, 4'h1, 2, -1, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL stretch cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_stop();
    int sp [2] = '{1, 6};
    for (int k = 0; k < 2; k++) begin
      run_sched(3, 4'h0, 0, sp[k], -1, -1, -1, 0);
      for (int c = 0; c < obs.size(); c++) begin
        n_checks++;
        if (obs[c] !== expq[c]) begin
          n_errors++;
          $display("FAIL stop%0d cyc=%0d got=%h want=%h", sp[k], c, obs[c], expq[c]);
        end
      end
    end
  endtask

  task automatic test_load_err();
    run_sched(3, 4'h0, 2, -1, 3, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL load_err cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
    run_sched(3, 4'h0, 1, -1, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL load_err_replay cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_drain_stretch();
    run_sched(3, 4'h8, 1, -1, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL drain_stretch cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_rst_mid();
    run_sched(3, 4'h2, 3, -1, -1, 4, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL rst_mid cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
    run_sched(3, 4'h0, 2, -1, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL rst_replay cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_start_stop();
    run_sched(3, 4'h0, 2, -1, -1, -1, -1, 1);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL start_stop cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_saturate();
    ram_m[0] = 4'h5; ram_m[1] = 4'hA;
    load_ram(1, 0);
    run_sched(1, 4'h3, 0, 17, -1, -1, -1, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL saturate cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int pm1, niter, stop_at;
      logic [CW-1:0] mask;
      pm1     = (k == 0) ? 7 : $urandom_range(0, 7);
      niter   = $urandom_range(1, 3);
      mask    = CW'($urandom);
      stop_at = $urandom_range(0, 1) ? $urandom_range(0, niter * eff_period(pm1) - 1) : -1;
      load_ram(pm1, 1);
      run_sched(pm1, mask, niter, stop_at, -1, -1, -1, 0);
      for (int c = 0; c < obs.size(); c++) begin
        n_checks++;
        if (obs[c] !== expq[c]) begin
          n_errors++;
          $display("FAIL random%0d pm1=%0d cyc=%0d got=%h want=%h", k, pm1, c, obs[c], expq[c]);
        end
      end
    end
  endtask

`ifdef BUFF_SCHED_ABORT_EN
  task automatic test_abort();
    load_ram(3, 1);
    run_sched(3, 4'hF, 2, -1, -1, -1, 5, 0);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== expq[c]) begin
        n_errors++;
        $display("FAIL abort cyc=%0d got=%h want=%h", c, obs[c], expq[c]);
      end
    end
  endtask
`endif

  initial begin
    idle_inputs();
    bus.period_m1    = '0;
    bus.stretch_mask = '0;
    bus.num_iter     = '0;
    test_reset();
    test_basic();
    test_stretch();
    test_stop();
    test_load_err();
    test_drain_stretch();
    test_rst_mid();
    test_start_stop();
    test_saturate();
    test_random();
`ifdef BUFF_SCHED_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/buff_sched_ctrl.md
Name: buff_sched_ctrl

Overview:
Parametrised buffer-toggle schedule controller, the successor to the fixed 12-buffer/48-cycle controller. It holds a programmable schedule RAM of per-cycle control words and replays it cyclically to drive per-buffer write/read toggle strobes. Channel count, schedule depth, per-strobe pulse stretching, iteration count and graceful stop are all parameters or run-time settings. It sits between the host/config loader and the dataflow buffer bank.

Parameters:
NUM_BUFS, 12, number of buffers; control word width CW = 2*NUM_BUFS
MAX_PERIOD, 64, schedule RAM depth (maximum iteration period in cycles)
AW, $clog2(MAX_PERIOD), schedule address width
ITW, 16, iteration counter width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ctrl_in  in  CW  schedule word; bit 2i = wr toggle of buffer i, bit 2i+1 = rd toggle of buffer i
load_ctrl  in  1  write ctrl_in at wr_addr, then advance wr_addr
period_m1  in  AW  iteration period minus 1, latched at start
stretch_mask  in  CW  per-bit stretch enable, latched at start
num_iter  in  ITW  iterations to run, 0 = run forever, latched at start
start_ctrl  in  1  start pulse
stop_ctrl  in  1  graceful stop request
buff_wr_toggle  out  NUM_BUFS  write toggle strobes
buff_rd_toggle  out  NUM_BUFS  read toggle strobes
active  out  1  high in RUN or DRAIN
iter_cnt  out  ITW  completed iterations since the last start
done  out  1  one-cycle pulse when the run ends
load_err  out  1  one-cycle pulse when load_ctrl is rejected

Behaviour:
- Reset: state IDLE; wr_addr, rd_addr, iter_cnt, stop_pending, the prev word register and all outputs are 0. RAM contents are not cleared.
- Load: accepted only in IDLE. Writes RAM[wr_addr]. wr_addr wraps to 0 after reaching period_m1 (live input); otherwise it increments. load_ctrl in RUN or DRAIN: no write, load_err=1 on the next cycle.
- Effective period: P = min(latched period_m1, MAX_PERIOD-1) + 1.
- FSM IDLE -> RUN: start_ctrl sampled at edge k latches the settings and sets rd_addr=0, iter_cnt=0, stop_pending=0. Toggles show word 0 after edge k+1. Latency is 1 cycle from entering RUN.
- RUN, each cycle: cur = RAM[rd_addr] (combinational read); out <= cur | (mask & prev); prev <= cur. Stretched bits therefore produce a 2-cycle pulse, and stretching carries across the wrap boundary.
- stop_ctrl in RUN sets stop_pending. The current iteration always completes.
- Wrap in RUN (rd_addr==P-1): rd_addr <= 0 and iter_cnt <= iter_cnt+1 (saturates at all-ones). If stop_pending, or (num_iter!=0 and iter_cnt+1==num_iter), go to DRAIN.
- DRAIN (exactly 1 cycle): out <= mask & prev; prev <= 0. Then go to IDLE with done=1 for that one cycle.
- IDLE: out <= 0.
- start_ctrl in RUN or DRAIN: ignored. stop_ctrl in IDLE: ignored. start_ctrl and stop_ctrl together in IDLE: start wins, stop is dropped.
- rst mid-run: every register returns to its reset value at that edge. No done pulse.
- iter_cnt holds its value in IDLE until the next start.

Optional Feature:
BUFF_SCHED_ABORT_EN
- Defined: adds input abort_ctrl (1 bit, highest priority after rst). In RUN or DRAIN, abort_ctrl forces IDLE at the next edge: outputs 0, prev 0, no done pulse, iter_cnt held.
- Undefined: the port is absent and stop_ctrl is the only way to end a run early.

Test Plan:
- NUM_BUFS=2, load 4 words {0x1,0x2,0x4,0x8}, period_m1=3, mask=0, num_iter=2 -> wr0,rd0,wr1,rd1 single pulses twice; done 1 cycle after the 8th word; iter_cnt=2.
- Same schedule, mask=0x1 -> buff_wr_toggle[0] high 2 consecutive cycles each iteration; no other bit changes.
- num_iter=0, stop_ctrl mid-iteration (cycle 1) -> iteration finishes through word 3, one DRAIN cycle, then IDLE; done=1; iter_cnt equals iterations completed.
- load_ctrl while active -> RAM unchanged (replay identical), load_err=1 for 1 cycle.
- mask=0x8 with word 3=0x8 as the last word -> DRAIN cycle outputs rd1=1, then all toggles 0.
- rst asserted at cycle 5 of a run -> next cycle all outputs, active and iter_cnt are 0; no done pulse; a following start replays the retained RAM correctly.
